// File: rtl/data_bus_arbiter_pkg.sv
// Shared encodings for the data bus arbiter and the 3-to-1 data bus multiplexer.
// Select codes live here so the arbiter and the mux decode the same constants.
package data_bus_arbiter_pkg;

    localparam int NUM_SRC = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_RF   = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_MEM = 2'd1;
    localparam logic [1:0] REQ_RF  = 2'd2;

    // Round-robin successor, modulo the three requesters.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i >= REQ_RF) ? REQ_ALU : i + 2'd1;
    endfunction

    function automatic logic [1:0] idx2sel(input logic [1:0] i);
        case (i)
            REQ_ALU: return SEL_ALU;
            REQ_MEM: return SEL_MEM;
            REQ_RF:  return SEL_RF;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Request/grant bundle between the bus sources and the arbiter.
// master = requester side, slave = arbiter side.
interface data_bus_arbiter_if;
    import data_bus_arbiter_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic [1:0]         data_bus_sel;
    logic               bus_valid;
    logic               timeout_err;
    logic [1:0]         owner_id;

    modport master (
        output req,
        input  grant, data_bus_sel, bus_valid, timeout_err, owner_id
    );

    modport slave (
        input  req,
        output grant, data_bus_sel, bus_valid, timeout_err, owner_id
    );

endinterface

// File: rtl/data_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first eligible index scanning
// last+1, last+2, last (mod 3).
module rr_priority_pick
    import data_bus_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible_i,
    input  logic [1:0]         last_i,
    output logic [1:0]         pick_o,
    output logic               any_o
);

    logic [1:0] cand0;
    logic [1:0] cand1;

    always_comb begin
        cand0  = next_idx(last_i);
        cand1  = next_idx(cand0);
        pick_o = last_i;
        if (eligible_i[cand0]) begin
            pick_o = cand0;
        end else if (eligible_i[cand1]) begin
            pick_o = cand1;
        end
        any_o = |eligible_i;
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin owner sequencing for the shared data bus with hold limit,
// timeout lockout and a turnaround gap between owners. All outputs registered.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    data_bus_arbiter_if.slave bus_if
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [1:0] TURN_C     = 2'(TURNAROUND);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [1:0]         sel_q, sel_d;
    logic               tmo_q, tmo_d;
    logic [1:0]         owner_q, owner_d;
    logic [7:0]         hold_q, hold_d;
    logic [1:0]         gap_q, gap_d;
    logic [NUM_SRC-1:0] lock_q, lock_d;

    logic [NUM_SRC-1:0] eligible;
    logic [1:0]         pick;
    logic               any_elig;
    logic               own_req;
    logic               hold_at_max;
    logic               gap_done;

    assign eligible    = bus_if.req & ~lock_q;
    assign own_req     = bus_if.req[owner_q];
    assign hold_at_max = (hold_q == MAX_HOLD_C);
    assign gap_done    = (gap_q == TURN_C);

    rr_priority_pick u_pick (
        .eligible_i (eligible),
        .last_i     (owner_q),
        .pick_o     (pick),
        .any_o      (any_elig)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SEL_NONE;
            tmo_q   <= 1'b0;
            owner_q <= REQ_RF;
            hold_q  <= '0;
            gap_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any_elig) state_d = OWN;
            OWN: begin
                if (!own_req || hold_at_max) begin
                    state_d = (TURNAROUND > 0) ? GAP : IDLE;
                end
            end
            GAP: if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        sel_d   = sel_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        tmo_d   = 1'b0;
        // A dropped request always clears its lockout, whatever the state.
        lock_d  = lock_q & bus_if.req;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    grant_d = 3'b001 << pick;
                    sel_d   = idx2sel(pick);
                    owner_d = pick;
                    hold_d  = 8'd1;
                end
            end
            OWN: begin
                if (!own_req) begin
                    grant_d = '0;
                    sel_d   = SEL_NONE;
                    gap_d   = 2'd1;
                end else if (hold_at_max) begin
                    grant_d         = '0;
                    sel_d           = SEL_NONE;
                    gap_d           = 2'd1;
                    tmo_d           = 1'b1;
                    lock_d[owner_q] = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            GAP: gap_d = gap_q + 2'd1;
            default: ;
        endcase
    end

    assign bus_if.grant        = grant_q;
    assign bus_if.data_bus_sel = sel_q;
    assign bus_if.bus_valid    = |grant_q;
    assign bus_if.timeout_err  = tmo_q;
    assign bus_if.owner_id     = owner_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench: three arbiter instances cover default timing, MAX_HOLD=4
// timeout/tie behaviour and TURNAROUND=0 back-to-back handover.
module tb_data_bus_arbiter;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    data_bus_arbiter_if ifa ();
    data_bus_arbiter_if ifb ();
    data_bus_arbiter_if ifc ();

    data_bus_arbiter #(.MAX_HOLD(8), .TURNAROUND(1)) dut_a (
        .clk_i (clk), .rst_i (rst), .bus_if (ifa.slave)
    );
    data_bus_arbiter #(.MAX_HOLD(4), .TURNAROUND(1)) dut_b (
        .clk_i (clk), .rst_i (rst), .bus_if (ifb.slave)
    );
    data_bus_arbiter #(.MAX_HOLD(8), .TURNAROUND(0)) dut_c (
        .clk_i (clk), .rst_i (rst), .bus_if (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ifa.req  = '0;
        ifb.req  = '0;
        ifc.req  = '0;
        tick();
        tick();
        chk("rst_grant", ifa.grant, 8'h0);
        chk("rst_sel", ifa.data_bus_sel, 8'h3);
        chk("rst_owner", ifa.owner_id, 8'h2);
        chk("rst_valid", ifa.bus_valid, 8'h0);
        chk("rst_tmo", ifa.timeout_err, 8'h0);
        chk("rst_owner_b", ifb.owner_id, 8'h2);
        chk("rst_sel_c", ifc.data_bus_sel, 8'h3);
        rst = 1'b0;

        // Reset while memory owns the bus
        ifa.req = 3'b010;
        tick();
        chk("mid_grant", ifa.grant, 8'h2);
        chk("mid_sel", ifa.data_bus_sel, 8'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_grant", ifa.grant, 8'h0);
        chk("mid_rst_sel", ifa.data_bus_sel, 8'h3);
        chk("mid_rst_owner", ifa.owner_id, 8'h2);
        chk("mid_rst_tmo", ifa.timeout_err, 8'h0);
        chk("mid_rst_valid", ifa.bus_valid, 8'h0);
        rst = 1'b0;
        ifa.req = 3'b000;
        tick();
        chk("post_rst_idle", ifa.grant, 8'h0);

        // Round-robin: all request, each owner drops after 2 cycles
        ifa.req = 3'b111;
        tick();
        chk("rr_alu", ifa.grant, 8'h1);
        chk("rr_alu_owner", ifa.owner_id, 8'h0);
        tick();
        chk("rr_alu_hold", ifa.grant, 8'h1);
        ifa.req = 3'b110;
        tick();
        chk("rr_alu_rel", ifa.grant, 8'h0);
        chk("rr_alu_rel_sel", ifa.data_bus_sel, 8'h3);
        ifa.req = 3'b111;
        tick();
        chk("rr_gap1", ifa.grant, 8'h0);
        tick();
        chk("rr_mem", ifa.grant, 8'h2);
        chk("rr_mem_sel", ifa.data_bus_sel, 8'h1);
        tick();
        chk("rr_mem_hold", ifa.grant, 8'h2);
        ifa.req = 3'b101;
        tick();
        chk("rr_mem_rel", ifa.grant, 8'h0);
        ifa.req = 3'b111;
        tick();
        chk("rr_gap2", ifa.grant, 8'h0);
        tick();
        chk("rr_rf", ifa.grant, 8'h4);
        chk("rr_rf_sel", ifa.data_bus_sel, 8'h2);
        chk("rr_rf_valid", ifa.bus_valid, 8'h1);
        tick();
        chk("rr_rf_hold", ifa.grant, 8'h4);
        ifa.req = 3'b011;
        tick();
        chk("rr_rf_rel", ifa.grant, 8'h0);
        ifa.req = 3'b111;
        tick();
        tick();
        chk("rr_alu2", ifa.grant, 8'h1);
        chk("rr_alu2_sel", ifa.data_bus_sel, 8'h0);
        ifa.req = 3'b000;
        tick();
        tick();

        // Single memory request held 3 cycles, then gap and idle
        ifa.req = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_grant", ifa.grant, 8'h2);
            chk("single_sel", ifa.data_bus_sel, 8'h1);
        end
        ifa.req = 3'b000;
        tick();
        chk("single_gap_grant", ifa.grant, 8'h0);
        chk("single_gap_sel", ifa.data_bus_sel, 8'h3);
        tick();
        chk("single_idle_sel", ifa.data_bus_sel, 8'h3);
        chk("single_idle_valid", ifa.bus_valid, 8'h0);
        tick();
        chk("single_stay_idle", ifa.grant, 8'h0);

        // Timeout: MAX_HOLD=4, ALU holds req for 10 edges
        ifb.req = 3'b001;
        tick();
        chk("to_grant", ifb.grant, 8'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold", ifb.grant, 8'h1);
            chk("to_no_tmo", ifb.timeout_err, 8'h0);
        end
        tick();
        chk("to_forced_rel", ifb.grant, 8'h0);
        chk("to_pulse", ifb.timeout_err, 8'h1);
        tick();
        chk("to_pulse_end", ifb.timeout_err, 8'h0);
        chk("to_gap", ifb.grant, 8'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_locked", ifb.grant, 8'h0);
        end
        ifb.req = 3'b000;
        tick();
        chk("to_drop", ifb.grant, 8'h0);
        ifb.req = 3'b001;
        tick();
        chk("to_regrant", ifb.grant, 8'h1);
        chk("to_regrant_tmo", ifb.timeout_err, 8'h0);

        // Tie at limit: owner drops exactly when the counter reaches MAX_HOLD
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tie_hold", ifb.grant, 8'h1);
        end
        ifb.req = 3'b000;
        tick();
        chk("tie_rel", ifb.grant, 8'h0);
        chk("tie_no_tmo", ifb.timeout_err, 8'h0);
        ifb.req = 3'b001;
        tick();
        chk("tie_gap", ifb.grant, 8'h0);
        tick();
        chk("tie_regrant", ifb.grant, 8'h1);
        chk("tie_regrant_tmo", ifb.timeout_err, 8'h0);
        ifb.req = 3'b000;
        tick();

        // TURNAROUND=0: memory then RF back-to-back, one idle cycle
        ifc.req = 3'b010;
        tick();
        chk("t0_mem", ifc.grant, 8'h2);
        ifc.req = 3'b110;
        tick();
        chk("t0_mem_hold", ifc.grant, 8'h2);
        ifc.req = 3'b100;
        tick();
        chk("t0_idle_grant", ifc.grant, 8'h0);
        chk("t0_idle_sel", ifc.data_bus_sel, 8'h3);
        tick();
        chk("t0_rf", ifc.grant, 8'h4);
        chk("t0_rf_sel", ifc.data_bus_sel, 8'h2);
        chk("t0_rf_owner", ifc.owner_id, 8'h2);
        ifc.req = 3'b000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
